// File: rtl/latch_mon_pkg.sv
// latch_mon_pkg: shared FSM state type, default parameters and width helper for the latch edge monitor
package latch_mon_pkg;
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_e;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;
  localparam int CNT_W_DEF       = 8;
  // debounce counter width: enough to hold DEBOUNCE_CYCLES, never below one bit
  function automatic int db_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/latch_edge_monitor_if.sv
// latch_edge_monitor_if: latch sample input, control and status bundle
//   master: drives Qin/En/Clr, observes Qstable/Rise/Fall/Rise_Cnt/Fall_Cnt/Sat
//   slave : the monitor side
interface latch_edge_monitor_if
  import latch_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             Qin;
  logic             En;
  logic             Clr;
  logic             Qstable;
  logic             Rise;
  logic             Fall;
  logic [CNT_W-1:0] Rise_Cnt;
  logic [CNT_W-1:0] Fall_Cnt;
  logic             Sat;
  modport master (output Qin, En, Clr, input Qstable, Rise, Fall, Rise_Cnt, Fall_Cnt, Sat);
  modport slave  (input Qin, En, Clr, output Qstable, Rise, Fall, Rise_Cnt, Fall_Cnt, Sat);
endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain bringing an asynchronous bit into the Clk domain
//   Clk, Rst_n (sync, active-low) ; d_i async input ; q_o synchronized output (last stage)
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge Clk) sync_q <= !Rst_n ? '0 : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/latch_edge_monitor.sv
// latch_edge_monitor: synchronizes and debounces latch Qout, emits rise/fall pulses and saturating event counts
//   Clk, Rst_n (sync, active-low)
//   bus.Qin async level, bus.En freeze control, bus.Clr counter/Sat clear
//   bus.Qstable debounced level, bus.Rise/bus.Fall one-cycle pulses,
//   bus.Rise_Cnt/bus.Fall_Cnt saturating counts, bus.Sat sticky saturation flag
module latch_edge_monitor
  import latch_mon_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Rst_n,
  latch_edge_monitor_if.slave bus
);
  localparam int               DW       = db_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]    DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);
  logic             s;
  state_e           state_q, state_d;
  logic [DW-1:0]    db_q, db_d;
  logic             qstable_q, qstable_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d, fall_cnt_q, fall_cnt_d;
  logic             sat_q, sat_d;
  logic             done, rise_inc, fall_inc;
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .d_i  (bus.Qin),
    .q_o  (s)
  );
  assign done = (db_q == DB_LAST);
  always_ff @(posedge Clk) state_q <= !Rst_n ? IDLE_LO : state_d;
  // a disabled monitor abandons any debounce in progress and holds its idle level
  always_comb begin
    state_d = state_q;
    if (!bus.En)
      state_d = (state_q == CHK_HI) ? IDLE_LO : (state_q == CHK_LO) ? IDLE_HI : state_q;
    else
      case (state_q)
        IDLE_LO: state_d = !s ? IDLE_LO : (DEBOUNCE_CYCLES == 1) ? IDLE_HI : CHK_HI;
        CHK_HI:  state_d = !s ? IDLE_LO : done ? IDLE_HI : CHK_HI;
        IDLE_HI: state_d = s ? IDLE_HI : (DEBOUNCE_CYCLES == 1) ? IDLE_LO : CHK_LO;
        CHK_LO:  state_d = s ? IDLE_HI : done ? IDLE_LO : CHK_LO;
        default: state_d = IDLE_LO;
      endcase
  end
  // pulses mark only accepted changes; a CHK state falling back to its own IDLE is a rejected glitch
  always_comb begin
    rise_d     = (state_d == IDLE_HI) && (state_q == IDLE_LO || state_q == CHK_HI);
    fall_d     = (state_d == IDLE_LO) && (state_q == IDLE_HI || state_q == CHK_LO);
    qstable_d  = (state_d == IDLE_HI) || (state_d == CHK_LO);
    db_d       = (state_d == CHK_HI || state_d == CHK_LO)
               ? ((state_q == state_d) ? db_q + DW'(1) : DW'(1)) : '0;
    rise_inc   = rise_q && bus.En;
    fall_inc   = fall_q && bus.En;
    rise_cnt_d = bus.Clr ? '0 : (rise_inc && rise_cnt_q != CNT_MAX) ? rise_cnt_q + CNT_W'(1) : rise_cnt_q;
    fall_cnt_d = bus.Clr ? '0 : (fall_inc && fall_cnt_q != CNT_MAX) ? fall_cnt_q + CNT_W'(1) : fall_cnt_q;
    sat_d      = bus.Clr ? 1'b0
               : sat_q | (rise_inc && rise_cnt_q >= CNT_NEAR) | (fall_inc && fall_cnt_q >= CNT_NEAR);
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      db_q       <= '0;
      qstable_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      db_q       <= db_d;
      qstable_q  <= qstable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      sat_q      <= sat_d;
    end
  end
  assign bus.Qstable  = qstable_q;
  assign bus.Rise     = rise_q;
  assign bus.Fall     = fall_q;
  assign bus.Rise_Cnt = rise_cnt_q;
  assign bus.Fall_Cnt = fall_cnt_q;
  assign bus.Sat      = sat_q;
endmodule

// File: tb/tb_latch_edge_monitor.sv
// tb_latch_edge_monitor: three monitor configurations driven together, checked by a scoreboard against a run-length model
module tb_latch_edge_monitor;
  typedef struct packed {
    logic       qs;
    logic       rise;
    logic       fall;
    logic       sat;
    logic [7:0] rc;
    logic [7:0] fc;
  } obs_t;
  typedef obs_t [2:0] cyc_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0, qin = 1'b0, en = 1'b1, clr = 1'b0;
  int   errors = 0, checks = 0, cycle = 0;
  cyc_t sb[$];
  always #5 Clk = ~Clk;
  latch_edge_monitor_if #(.CNT_W(8)) ifa ();
  latch_edge_monitor_if #(.CNT_W(2)) ifb ();
  latch_edge_monitor_if #(.CNT_W(3)) ifc ();
  assign ifa.Qin = qin; assign ifa.En = en; assign ifa.Clr = clr;
  assign ifb.Qin = qin; assign ifb.En = en; assign ifb.Clr = clr;
  assign ifc.Qin = qin; assign ifc.En = en; assign ifc.Clr = clr;
  latch_edge_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ifa));
  latch_edge_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ifb));
  latch_edge_monitor #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(3)) dut_c (.Clk(Clk), .Rst_n(Rst_n), .bus(ifc));
  // reference: a level is accepted after DEB consecutive enabled samples that disagree with it
  int sy[3] = '{2, 2, 3};
  int db[3] = '{4, 4, 1};
  int cm[3] = '{255, 3, 7};
  int pipe[3][4];
  int stable[3], run[3], rc[3], fc[3], rp[3], fp[3], sat[3];
  always @(posedge Clk) begin
    cyc_t e;
    for (int k = 0; k < 3; k++) begin
      if (!Rst_n) begin
        for (int i = 0; i < 4; i++) pipe[k][i] = 0;
        stable[k] = 0; run[k] = 0; rc[k] = 0; fc[k] = 0; rp[k] = 0; fp[k] = 0; sat[k] = 0;
      end else begin
        int sv, nr, nf;
        sv = pipe[k][sy[k]-1];
        for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        pipe[k][0] = int'(qin);
        if (clr) begin
          rc[k] = 0; fc[k] = 0; sat[k] = 0;
        end else if (en) begin
          if (rp[k] != 0) begin
            if (rc[k] < cm[k]) rc[k]++;
            if (rc[k] == cm[k]) sat[k] = 1;
          end
          if (fp[k] != 0) begin
            if (fc[k] < cm[k]) fc[k]++;
            if (fc[k] == cm[k]) sat[k] = 1;
          end
        end
        nr = 0; nf = 0;
        if (en && sv != stable[k]) begin
          run[k]++;
          if (run[k] == db[k]) begin
            stable[k] = sv; run[k] = 0;
            if (sv != 0) nr = 1; else nf = 1;
          end
        end else run[k] = 0;
        rp[k] = nr; fp[k] = nf;
      end
      e[k] = '{qs: stable[k][0], rise: rp[k][0], fall: fp[k][0], sat: sat[k][0], rc: 8'(rc[k]), fc: 8'(fc[k])};
    end
    sb.push_back(e);
    cycle++;
  end
  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      cyc_t e, a;
      e = sb.pop_front();
      a[0] = '{qs: ifa.Qstable, rise: ifa.Rise, fall: ifa.Fall, sat: ifa.Sat, rc: ifa.Rise_Cnt, fc: ifa.Fall_Cnt};
      a[1] = '{qs: ifb.Qstable, rise: ifb.Rise, fall: ifb.Fall, sat: ifb.Sat, rc: 8'(ifb.Rise_Cnt), fc: 8'(ifb.Fall_Cnt)};
      a[2] = '{qs: ifc.Qstable, rise: ifc.Rise, fall: ifc.Fall, sat: ifc.Sat, rc: 8'(ifc.Rise_Cnt), fc: 8'(ifc.Fall_Cnt)};
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a[k] !== e[k]) begin
          errors++;
          $display("FAIL sb dut%0d cycle %0d: got qs=%b rise=%b fall=%b sat=%b rc=%0d fc=%0d, want qs=%b rise=%b fall=%b sat=%b rc=%0d fc=%0d",
                   k, cycle, a[k].qs, a[k].rise, a[k].fall, a[k].sat, a[k].rc, a[k].fc,
                   e[k].qs, e[k].rise, e[k].fall, e[k].sat, e[k].rc, e[k].fc);
        end
      end
    end
  end
  task automatic hold(input int n, input logic q, input logic e, input logic c, input logic r);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      #1;
      qin = q; en = e; clr = c; Rst_n = r;
    end
  endtask
  initial begin
    int n;
    hold(3, 0, 1, 0, 0);
    hold(20, 0, 1, 0, 1);
    // latency from the setup edge to Qstable on the default configuration
    @(negedge Clk);
    #1;
    qin = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      n++;
      if (ifa.Qstable) break;
    end
    checks++;
    if (!ifa.Qstable || n - 1 != 5) begin
      errors++;
      $display("FAIL latency: got %0d edges (Qstable=%b), want 5", n - 1, ifa.Qstable);
    end
    hold(8, 1, 1, 0, 1);
    hold(12, 0, 1, 0, 1);
    hold(2, 1, 1, 0, 1);
    hold(10, 0, 1, 0, 1);
    hold(4, 1, 1, 0, 1);
    hold(12, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      hold(8, 1, 1, 0, 1);
      hold(8, 0, 1, 0, 1);
    end
    hold(1, 0, 1, 1, 1);
    hold(5, 0, 1, 0, 1);
    hold(4, 1, 1, 0, 1);
    hold(4, 1, 0, 0, 1);
    hold(10, 1, 1, 0, 1);
    hold(1, 1, 1, 0, 0);
    hold(12, 1, 1, 0, 1);
    hold(10, 0, 1, 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic q;
      int len;
      q = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++)
        hold(1, q, $urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 255) != 0);
    end
    hold(4, 0, 1, 0, 1);
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
